// File: rtl/serial_frame_assembler.sv
// Serial-to-parallel frame assembler: shifts qualified bits MSB-first into a word and
// pushes complete words into a small valid/ready FIFO with overflow and frame counting.
module serial_frame_assembler #(
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clk_en,
    input  logic                             i_ser_in,
    input  logic                             i_ser_in_valid,
    input  logic                             i_data_ready,
    input  logic                             i_clr_flags,
    output logic [FRAME_BITS-1:0]            o_data_out,
    output logic                             o_data_valid,
    output logic [$clog2(FRAME_BITS+1)-1:0]  o_bit_cnt,
    output logic                             o_short_err,
    output logic                             o_overflow,
    output logic [CNT_W-1:0]                 o_frame_cnt
);

    localparam int unsigned BW = $clog2(FRAME_BITS + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    typedef enum logic [0:0] {StIdle, StRecv} state_t;

    state_t                r_state, w_state_d;
    logic [FRAME_BITS-2:0] r_shift, w_shift_d;
    logic [BW-1:0]         r_bit_cnt, w_bit_cnt_d;
    logic                  r_short_err, w_short;
    logic                  w_push;
    logic [FRAME_BITS-1:0] w_word;

    logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    logic                  r_overflow;
    logic [CNT_W-1:0]      r_frame_cnt;
    logic                  w_empty, w_full, w_pop, w_accept, w_ovf_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_short_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_shift     <= w_shift_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_short_err <= w_short;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_push      = 1'b0;
        w_short     = 1'b0;
        w_word      = {r_shift, i_ser_in};
        if (i_clk_en) begin
            case (r_state)
                StIdle: begin
                    if (i_ser_in_valid) begin
                        w_shift_d   = (FRAME_BITS-1)'(i_ser_in);
                        w_bit_cnt_d = BW'(1);
                        w_state_d   = StRecv;
                    end
                end
                StRecv: begin
                    if (!i_ser_in_valid) begin
                        w_shift_d   = '0;
                        w_bit_cnt_d = '0;
                        w_short     = 1'b1;
                        w_state_d   = StIdle;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        w_push      = 1'b1;
                        w_shift_d   = '0;
                        w_bit_cnt_d = '0;
                        w_state_d   = StIdle;
                    end else begin
                        w_shift_d   = w_word[FRAME_BITS-2:0];
                        w_bit_cnt_d = r_bit_cnt + BW'(1);
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && i_data_ready;
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_word;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
                r_frame_cnt             <= r_frame_cnt + CNT_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (i_clr_flags) r_overflow <= 1'b0;
        end
    end

    assign o_data_out   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_data_valid = !w_empty;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_short_err  = r_short_err;
    assign o_overflow   = r_overflow;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_serial_frame_assembler.sv
// Directed self-checking bench for serial_frame_assembler (FRAME_BITS=10, FIFO_DEPTH=2).
module tb_serial_frame_assembler;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en, ser_in, ser_in_valid, data_ready, clr_flags;
    logic [9:0] data_out;
    logic       data_valid;
    logic [3:0] bit_cnt;
    logic       short_err, overflow;
    logic [7:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int short_seen;

    serial_frame_assembler #(
        .FRAME_BITS(10),
        .FIFO_DEPTH(2),
        .CNT_W     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_clk_en      (clk_en),
        .i_ser_in      (ser_in),
        .i_ser_in_valid(ser_in_valid),
        .i_data_ready  (data_ready),
        .i_clr_flags   (clr_flags),
        .o_data_out    (data_out),
        .o_data_valid  (data_valid),
        .o_bit_cnt     (bit_cnt),
        .o_short_err   (short_err),
        .o_overflow    (overflow),
        .o_frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_in       = b;
        ser_in_valid = 1'b1;
        clk_en       = 1'b1;
        tick();
    endtask

    // Sends a frame MSB-first on consecutive ticks; optionally raises ready on the last bit.
    task automatic send_frame(input logic [9:0] w, input logic ready_last);
        logic keep;
        keep = data_ready;
        for (int i = 9; i >= 0; i--) begin
            if (i == 0 && ready_last) data_ready = 1'b1;
            send_bit(w[i]);
        end
        data_ready = keep;
    endtask

    task automatic idle_tick();
        clk_en       = 1'b1;
        ser_in_valid = 1'b0;
        ser_in       = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},   data_valid, 0);
        check({tag, "_dout"}, data_out,   0);
        check({tag, "_bcnt"}, bit_cnt,    0);
        check({tag, "_serr"}, short_err,  0);
        check({tag, "_ovf"},  overflow,   0);
        check({tag, "_fcnt"}, frame_cnt,  0);
    endtask

    initial begin
        logic [9:0] bits1;
        bits1        = 10'b1011001110;
        rst          = 1'b1;
        clk_en       = 1'b0;
        ser_in       = 1'b0;
        ser_in_valid = 1'b0;
        data_ready   = 1'b0;
        clr_flags    = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // 1: basic frame, ready high throughout
        data_ready = 1'b1;
        for (int i = 9; i >= 1; i--) send_bit(bits1[i]);
        check("s1_bcnt9", bit_cnt, 9);
        check("s1_dv_pre", data_valid, 0);
        send_bit(bits1[0]);
        check("s1_dv", data_valid, 1);
        check("s1_dout", data_out, 10'h2CE);
        check("s1_fcnt", frame_cnt, 1);
        check("s1_bcnt0", bit_cnt, 0);
        idle_tick();
        check("s1_dv_1clk", data_valid, 0);

        // 2: truncated frame
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("s2_bcnt4", bit_cnt, 4);
        idle_tick();
        check("s2_serr", short_err, 1);
        check("s2_bcnt", bit_cnt, 0);
        check("s2_dv", data_valid, 0);
        idle_tick();
        check("s2_serr_pulse", short_err, 0);
        check("s2_fcnt", frame_cnt, 1);

        // 3: overflow with consumer stalled, frames back-to-back
        data_ready = 1'b0;
        send_frame(10'h155, 1'b0);
        check("s3_a_dout", data_out, 10'h155);
        send_frame(10'h0AA, 1'b0);
        check("s3_b_hold", data_out, 10'h155);
        check("s3_b_fcnt", frame_cnt, 3);
        check("s3_b_ovf", overflow, 0);
        send_frame(10'h3FF, 1'b0);
        clk_en       = 1'b0;
        ser_in_valid = 1'b0;
        check("s3_ovf", overflow, 1);
        check("s3_fcnt", frame_cnt, 3);
        check("s3_serr", short_err, 0);
        data_ready = 1'b1;
        tick();
        check("s3_pop_b", data_out, 10'h0AA);
        check("s3_pop_b_dv", data_valid, 1);
        tick();
        check("s3_empty", data_valid, 0);
        check("s3_ovf_sticky", overflow, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("s3_clr", overflow, 0);

        // 4: sparse clkEn with valid dropping between ticks
        data_ready = 1'b0;
        short_seen = 0;
        for (int i = 9; i >= 0; i--) begin
            ser_in       = bits1[i];
            ser_in_valid = 1'b1;
            clk_en       = 1'b1;
            tick();
            if (short_err) short_seen++;
            for (int k = 0; k < 3; k++) begin
                clk_en       = 1'b0;
                ser_in_valid = 1'b0;
                ser_in       = ~ser_in;
                tick();
                if (short_err) short_seen++;
            end
        end
        check("s4_noserr", short_seen, 0);
        check("s4_dout", data_out, 10'h2CE);
        check("s4_fcnt", frame_cnt, 4);
        data_ready = 1'b1;
        tick();
        check("s4_pop", data_valid, 0);

        // 5: async reset mid-frame with a word queued
        data_ready = 1'b0;
        send_frame(10'h123, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("s5_bcnt5", bit_cnt, 5);
        check("s5_dv", data_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s5_rst");
        tick();
        rst = 1'b0;
        clk_en = 1'b0;
        ser_in_valid = 1'b0;
        tick();
        send_frame(10'h2CE, 1'b0);
        clk_en = 1'b0;
        ser_in_valid = 1'b0;
        check("s5_dout", data_out, 10'h2CE);
        check("s5_fcnt", frame_cnt, 1);

        // 6: push into full FIFO with same-cycle pop
        send_frame(10'h1A5, 1'b0);
        check("s6_full_fcnt", frame_cnt, 2);
        send_frame(10'h06B, 1'b1);
        clk_en = 1'b0;
        ser_in_valid = 1'b0;
        check("s6_ovf", overflow, 0);
        check("s6_fcnt", frame_cnt, 3);
        check("s6_head", data_out, 10'h1A5);
        data_ready = 1'b1;
        tick();
        check("s6_next", data_out, 10'h06B);
        check("s6_next_dv", data_valid, 1);
        tick();
        check("s6_empty", data_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
